// File: rtl/joypad_pkg.sv
// Shared constants for the two-pad NES joypad port.
// Holds button bit indices, UART pad addresses and the debounce default.
package joypad_pkg;

    localparam int JP_A      = 0;
    localparam int JP_B      = 1;
    localparam int JP_SELECT = 2;
    localparam int JP_START  = 3;
    localparam int JP_UP     = 4;
    localparam int JP_DOWN   = 5;
    localparam int JP_LEFT   = 6;
    localparam int JP_RIGHT  = 7;

    localparam logic [7:0] JP_ADDR_PAD1 = 8'h40;
    localparam logic [7:0] JP_ADDR_PAD2 = 8'h41;

    localparam int JP_DEBOUNCE_DEFAULT = 21477;

    // A pad cannot report both directions of one axis at once
    function automatic logic [7:0] jp_mask_opposing(input logic [7:0] b);
        logic [7:0] m;
        m = b;
        if (b[JP_UP] && b[JP_DOWN]) begin
            m[JP_UP]   = 1'b0;
            m[JP_DOWN] = 1'b0;
        end
        if (b[JP_LEFT] && b[JP_RIGHT]) begin
            m[JP_LEFT]  = 1'b0;
            m[JP_RIGHT] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/joypad_port_debounce.sv
// Synchronizer plus tick-sampled two-sample agreement debouncer.
// A bit changes only when two consecutive tick samples agree.
module button_debounce #(
    parameter int WIDTH  = 8,
    parameter int CYCLES = 21477,
    parameter int CTR_W  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_db
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sample;
    logic [WIDTH-1:0] r_db;
    logic [CTR_W-1:0] r_ctr;
    logic             w_tick;
    logic [WIDTH-1:0] w_agree;

    assign w_tick  = (r_ctr == CTR_W'(CYCLES - 1));
    assign w_agree = ~(r_sync2 ^ r_sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sample <= '0;
            r_db     <= '0;
            r_ctr    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_ctr   <= w_tick ? '0 : r_ctr + 1'b1;
            if (w_tick) begin
                r_sample <= r_sync2;
                r_db     <= (w_agree & r_sync2) | (~w_agree & r_db);
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/joypad_port.sv
// Two-pad NES joypad port: UART/board sources, strobe latch, serial shift.
// Pad 1 may come from debounced board inputs; pad 2 is UART only.
module joypad_port
    import joypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = JP_DEBOUNCE_DEFAULT,
    parameter int CTR_W           = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] uart_data,
    input  logic [7:0] uart_addr,
    input  logic       uart_write,
    input  logic [4:0] btn,
    input  logic [2:0] sw_btn,
    input  logic       board_sel,
    input  logic       joypad_strobe,
    input  logic [1:0] joypad_clock,
    output logic [1:0] joypad_data,
    output logic [7:0] pad1_state,
    output logic [7:0] pad2_state
);

    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    logic [7:0] r_uart_pad1;
    logic [7:0] r_uart_pad2;
    logic [7:0] w_board_raw;
    logic [7:0] w_board_db;
    logic [7:0] w_pad [2];

    // Assert immediately, release on a clean clk edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_uart_pad1 <= 8'h00;
            r_uart_pad2 <= 8'h00;
        end else if (uart_write) begin
            if (uart_addr == JP_ADDR_PAD1) r_uart_pad1 <= uart_data;
            if (uart_addr == JP_ADDR_PAD2) r_uart_pad2 <= uart_data;
        end
    end

    always_comb begin
        w_board_raw            = 8'h00;
        w_board_raw[JP_A]      = btn[0];
        w_board_raw[JP_UP]     = btn[1];
        w_board_raw[JP_LEFT]   = btn[2];
        w_board_raw[JP_RIGHT]  = btn[3];
        w_board_raw[JP_DOWN]   = btn[4];
        w_board_raw[JP_B]      = sw_btn[0];
        w_board_raw[JP_SELECT] = sw_btn[1];
        w_board_raw[JP_START]  = sw_btn[2];
    end

    button_debounce #(
        .WIDTH  (8),
        .CYCLES (DEBOUNCE_CYCLES),
        .CTR_W  (CTR_W)
    ) u_debounce (
        .clk   (clk),
        .rst_n (w_rst_n),
        .i_raw (w_board_raw),
        .o_db  (w_board_db)
    );

    assign pad1_state = board_sel ? jp_mask_opposing(w_board_db)
                                  : r_uart_pad1;
    assign pad2_state = r_uart_pad2;
    assign w_pad[0]   = pad1_state;
    assign w_pad[1]   = pad2_state;

    for (genvar gi = 0; gi < 2; gi++) begin : g_pad
        logic       r_prev_clk;
        logic [7:0] r_shift;
        logic       w_fall;

        assign w_fall = r_prev_clk & ~joypad_clock[gi];

        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_prev_clk <= 1'b0;
                r_shift    <= 8'h00;
            end else begin
                r_prev_clk <= joypad_clock[gi];
                if (joypad_strobe) r_shift <= w_pad[gi];
                else if (w_fall)   r_shift <= {1'b1, r_shift[7:1]};
            end
        end

        assign joypad_data[gi] = r_shift[0];
    end

endmodule

// File: tb/tb_joypad_port.sv
// Directed self-checking bench for joypad_port.
// Uses a short debounce period so the board path settles quickly.
module tb_joypad_port;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] uart_data;
    logic [7:0] uart_addr;
    logic       uart_write;
    logic [4:0] btn;
    logic [2:0] sw_btn;
    logic       board_sel;
    logic       joypad_strobe;
    logic [1:0] joypad_clock;
    logic [1:0] joypad_data;
    logic [7:0] pad1_state;
    logic [7:0] pad2_state;

    int checks   = 0;
    int failures = 0;

    joypad_port #(
        .DEBOUNCE_CYCLES (4),
        .CTR_W           (15)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .uart_data     (uart_data),
        .uart_addr     (uart_addr),
        .uart_write    (uart_write),
        .btn           (btn),
        .sw_btn        (sw_btn),
        .board_sel     (board_sel),
        .joypad_strobe (joypad_strobe),
        .joypad_clock  (joypad_clock),
        .joypad_data   (joypad_data),
        .pad1_state    (pad1_state),
        .pad2_state    (pad2_state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic uart_wr(input logic [7:0] a, input logic [7:0] d);
        uart_addr  = a;
        uart_data  = d;
        uart_write = 1'b1;
        step();
        uart_write = 1'b0;
        uart_addr  = 8'h00;
    endtask

    task automatic strobe_pulse();
        joypad_strobe = 1'b1;
        step(2);
        joypad_strobe = 1'b0;
        step();
    endtask

    task automatic read_edge(input int p);
        joypad_clock[p] = 1'b1;
        step();
        joypad_clock[p] = 1'b0;
        step();
    endtask

    logic [7:0] seq;
    bit         found;

    initial begin
        reset_n       = 1'b0;
        uart_data     = 8'h00;
        uart_addr     = 8'h00;
        uart_write    = 1'b0;
        btn           = 5'b0;
        sw_btn        = 3'b0;
        board_sel     = 1'b0;
        joypad_strobe = 1'b0;
        joypad_clock  = 2'b00;
        step(3);
        check("rst_data", {6'b0, joypad_data}, 8'h00);
        check("rst_pad1", pad1_state, 8'h00);
        check("rst_pad2", pad2_state, 8'h00);
        reset_n = 1'b1;
        step(3);

        uart_wr(8'h40, 8'h81);
        check("uart_pad1", pad1_state, 8'h81);
        uart_wr(8'h42, 8'hFF);
        check("ignored_addr_p1", pad1_state, 8'h81);
        check("ignored_addr_p2", pad2_state, 8'h00);

        strobe_pulse();
        check("p1_bit0", {7'b0, joypad_data[0]}, 8'h01);
        seq = 8'h81;
        for (int k = 1; k < 10; k++) begin
            read_edge(0);
            check($sformatf("p1_bit%0d", k), {7'b0, joypad_data[0]},
                  (k < 8) ? {7'b0, seq[k]} : 8'h01);
            check($sformatf("p2_idle%0d", k), {7'b0, joypad_data[1]},
                  8'h00);
        end

        uart_wr(8'h41, 8'h0F);
        check("uart_pad2", pad2_state, 8'h0F);
        strobe_pulse();
        check("p2_bit0", {7'b0, joypad_data[1]}, 8'h01);
        seq = 8'h0F;
        for (int k = 1; k < 8; k++) begin
            read_edge(1);
            check($sformatf("p2_bit%0d", k), {7'b0, joypad_data[1]},
                  {7'b0, seq[k]});
        end
        check("p1_unchanged", pad1_state, 8'h81);

        uart_wr(8'h40, 8'h01);
        joypad_strobe = 1'b1;
        step(2);
        for (int k = 0; k < 4; k++) begin
            read_edge(0);
            check($sformatf("strobe_hold%0d", k), {7'b0, joypad_data[0]},
                  8'h01);
        end
        joypad_clock[0] = 1'b1;
        step();
        joypad_strobe = 1'b0;
        step();
        joypad_clock[0] = 1'b0;
        step();
        check("first_shift", {7'b0, joypad_data[0]}, 8'h00);

        board_sel = 1'b1;
        step(20);
        check("board_idle", pad1_state, 8'h00);
        for (int k = 0; k < 5; k++) begin
            btn[0] = 1'b1;
            for (int j = 0; j < 3; j++) begin
                step();
                check("glitch_hi", pad1_state, 8'h00);
            end
            btn[0] = 1'b0;
            for (int j = 0; j < 9; j++) begin
                step();
                check("glitch_lo", pad1_state, 8'h00);
            end
        end

        btn[0] = 1'b1;
        found  = 1'b0;
        for (int c = 0; c < 15 && !found; c++) begin
            step();
            if (pad1_state == 8'h01) found = 1'b1;
        end
        check("steady_found", {7'b0, found}, 8'h01);
        check("steady_val", pad1_state, 8'h01);

        btn = 5'b10011;
        step(20);
        check("mask_updown", pad1_state, 8'h01);
        btn = 5'b00011;
        step(20);
        check("up_a", pad1_state, 8'h11);
        btn    = 5'b01101;
        sw_btn = 3'b101;
        step(20);
        check("lr_mask_sw", pad1_state, 8'h0B);

        board_sel = 1'b0;
        uart_wr(8'h40, 8'h30);
        check("uart_updown", pad1_state, 8'h30);

        strobe_pulse();
        for (int k = 0; k < 3; k++) read_edge(0);
        check("pre_rst_bit", {7'b0, joypad_data[0]}, 8'h00);
        reset_n = 1'b0;
        #1;
        check("mid_rst_data", {6'b0, joypad_data}, 8'h00);
        check("mid_rst_pad1", pad1_state, 8'h00);
        check("mid_rst_pad2", pad2_state, 8'h00);
        step(2);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("post_rst_data", {6'b0, joypad_data}, 8'h00);
        end
        uart_wr(8'h40, 8'h02);
        check("post_rst_uart", pad1_state, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
